// File: rtl/ef_smsdac_sin.sv
// Serial sample loader and playback FIFO feeding the segmented DAC d_in.
// Define EF_SMSDAC_SIN_MIDSCALE_EN to force d_out to midscale on underflow.
module ef_smsdac_sin #(
  parameter int unsigned DIV   = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sck,
  input  logic                     cs_b,
  input  logic                     mosi,
  input  logic                     clr_flags,
  output logic [7:0]               d_out,
  output logic                     d_valid,
  output logic                     ovf,
  output logic                     unf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(DIV);

  logic          sck_s1, sck_s2, sck_d;
  logic          cs_s1, cs_s2;
  logic          mosi_s1, mosi_s2;
  logic [7:0]    sr;
  logic [2:0]    bit_cnt;
  logic          push_pend;
  logic [TW-1:0] tmr;
  logic [AW-1:0] wptr, rptr;
  logic [7:0]    mem [DEPTH];

  logic          sck_rise;
  logic          strobe, full, empty, pop, push_ok, ovf_set, unf_set;
  logic [LW-1:0] level_nxt;

  // Two-flop synchronizers plus a delayed sck copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      cs_s1   <= cs_b;
      cs_s2   <= cs_s1;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sck_rise = sck_s2 & ~sck_d;

  // Receive shifter; a deasserted frame drops any partial byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= 8'h00;
      bit_cnt   <= 3'd0;
      push_pend <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      if (cs_s2) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise) begin
        sr        <= {sr[6:0], mosi_s2};
        bit_cnt   <= bit_cnt + 3'd1;
        push_pend <= (bit_cnt == 3'd7);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmr <= '0;
    else     tmr <= strobe ? '0 : tmr + TW'(1);
  end

  always_comb begin
    strobe  = (tmr == TW'(DIV - 1));
    full    = (level == LW'(DEPTH));
    empty   = (level == '0);
    pop     = strobe & ~empty;
    push_ok = push_pend & (~full | pop);
    ovf_set = push_pend & full & ~pop;
    unf_set = strobe & empty;
    case ({push_ok, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // Storage has no reset; pointers and level define what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= sr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      d_out   <= 8'h80;
      d_valid <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      level   <= level_nxt;
      d_valid <= pop;
      ovf     <= (ovf & ~clr_flags) | ovf_set;
      unf     <= (unf & ~clr_flags) | unf_set;
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr  <= rptr + AW'(1);
        d_out <= mem[rptr];
      end
`ifdef EF_SMSDAC_SIN_MIDSCALE_EN
      else if (unf_set) begin
        d_out <= 8'h80;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ef_smsdac_sin.sv
// Directed bench for ef_smsdac_sin (DIV=1024, DEPTH=4); honours EF_SMSDAC_SIN_MIDSCALE_EN.
module tb_ef_smsdac_sin;

  localparam int unsigned DIV   = 1024;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       cs_b = 1'b1;
  logic       mosi = 1'b0;
  logic       clr_flags = 1'b0;
  logic [7:0] d_out;
  logic       d_valid;
  logic       ovf;
  logic       unf;
  logic [2:0] level;

  int errors = 0;
  int checks = 0;

  ef_smsdac_sin #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_b(cs_b), .mosi(mosi),
    .clr_flags(clr_flags), .d_out(d_out), .d_valid(d_valid),
    .ovf(ovf), .unf(unf), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial bit: mosi set with sck low, then one sck high phase
  task automatic send_bit(input logic b, input int half);
    mosi = b;
    repeat (half) @(negedge clk);
    sck = 1'b1;
    repeat (half) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int half);
    for (int k = 7; k >= 0; k--) send_bit(b[k], half);
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(posedge clk); #1;
      if (d_valid) ok = 1'b1;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_flags = 1'b1;
    @(negedge clk); clr_flags = 1'b0;
  endtask

  initial begin
    bit         ok;
    bit         seen;
    logic [7:0] hold_exp;
    logic [7:0] a5;
`ifdef EF_SMSDAC_SIN_MIDSCALE_EN
    hold_exp = 8'h80;
`else
    hold_exp = 8'hA5;
`endif
    a5 = 8'hA5;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_dout", d_out, 8'h80);
    chk("rst_dvalid", d_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    chk("rst_level", level, 0);
    rst = 1'b0;

    // First strobe DIV cycles after release, empty -> underflow
    repeat (DIV - 1) @(posedge clk);
    #1;
    chk("unf_before_strobe", unf, 0);
    @(posedge clk); #1;
    chk("unf_first_strobe", unf, 1);
    chk("unf_no_valid", d_valid, 0);
    chk("unf_dout_mid", d_out, 8'h80);
    @(negedge clk); clr_flags = 1'b1;
    @(posedge clk); #1;
    chk("clr_unf", unf, 0);
    @(negedge clk); clr_flags = 1'b0;

    // Single byte A5 with push latency measured on the 8th bit
    cs_b = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 7; k >= 1; k--) send_bit(a5[k], 4);
    mosi = a5[0];
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("lat_level_3", level, 0);
    @(posedge clk); #1;
    chk("lat_level_4", level, 1);
    @(negedge clk);
    repeat (3) @(negedge clk);
    sck = 1'b0;
    repeat (4) @(negedge clk);
    cs_b = 1'b1;
    wait_valid(DIV + 100, ok);
    chk("single_valid_to", ok, 1);
    chk("single_dout", d_out, 8'hA5);
    chk("single_level", level, 0);
    @(posedge clk); #1;
    chk("single_valid_pulse", d_valid, 0);

    // Next strobe underflows: d_out holds or goes midscale
    repeat (DIV - 2) @(posedge clk);
    #1;
    chk("hold_unf_pre", unf, 0);
    @(posedge clk); #1;
    chk("hold_unf", unf, 1);
    chk("hold_valid", d_valid, 0);
    chk("hold_dout", d_out, hold_exp);

    // Async reset with a byte queued
    @(negedge clk);
    cs_b = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h5A, 4);
    cs_b = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_level", level, 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_level", level, 0);
    chk("arst_dout", d_out, 8'h80);
    chk("arst_unf", unf, 0);
    chk("arst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (DIV) begin
      @(posedge clk); #1;
      if (d_valid) seen = 1'b1;
    end
    chk("arst_no_valid", seen, 0);
    chk("arst_unf_strobe", unf, 1);
    pulse_clr();

    // Partial frame of 5 bits is discarded
    cs_b = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 5; k++) send_bit(1'b1, 4);
    repeat (4) @(negedge clk);
    cs_b = 1'b1;
    repeat (8) @(negedge clk);
    chk("partial_level0", level, 0);
    cs_b = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h3C, 4);
    cs_b = 1'b1;
    repeat (6) @(negedge clk);
    chk("partial_level1", level, 1);
    wait_valid(DIV + 100, ok);
    chk("partial_valid_to", ok, 1);
    chk("partial_dout", d_out, 8'h3C);

    // Overflow: DEPTH+2 bytes inside one playback period
    @(negedge clk);
    cs_b = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h11, 4);
    send_byte(8'h22, 4);
    send_byte(8'h33, 4);
    send_byte(8'h44, 4);
    chk("ovf_not_yet", ovf, 0);
    send_byte(8'h55, 4);
    send_byte(8'h66, 4);
    cs_b = 1'b1;
    repeat (6) @(negedge clk);
    chk("ovf_level", level, 3'(DEPTH));
    chk("ovf_flag", ovf, 1);
    wait_valid(DIV + 100, ok);
    chk("ovf_v1_to", ok, 1);
    chk("ovf_d1", d_out, 8'h11);
    wait_valid(DIV + 100, ok);
    chk("ovf_v2_to", ok, 1);
    chk("ovf_d2", d_out, 8'h22);
    wait_valid(DIV + 100, ok);
    chk("ovf_v3_to", ok, 1);
    chk("ovf_d3", d_out, 8'h33);
    wait_valid(DIV + 100, ok);
    chk("ovf_v4_to", ok, 1);
    chk("ovf_d4", d_out, 8'h44);
    chk("ovf_drained", level, 0);
    @(negedge clk); clr_flags = 1'b1;
    @(posedge clk); #1;
    chk("ovf_clr", ovf, 0);
    @(negedge clk); clr_flags = 1'b0;

    // Streaming 20 bytes, byte period slower than DIV
    fork
      begin
        @(negedge clk);
        cs_b = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 0; b < 20; b++) send_byte(8'(b), 68);
        cs_b = 1'b1;
      end
      begin
        bit sok;
        for (int i = 0; i < 20; i++) begin
          wait_valid(2500, sok);
          chk("stream_to", sok, 1);
          chk("stream_data", d_out, 16'(i));
        end
      end
    join
    chk("stream_ovf", ovf, 0);
    chk("stream_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
